id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the five-stage MIPS pipeline.
- Sits directly downstream of the Control unit and register file.
- Latches the decoded control bundle, operands and register addresses for the EX stage.
- Detects load-use hazards, inserts bubbles, and honours the stall and flush requests from the pipeline controller.

Parameters:
DATA_W, 32, width of operands, immediate and PC+4
REG_ADDR_W, 5, width of register specifiers
CTRL_W, 10, width of packed control bundle (fixed by ctrl bit order below)

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  downstream hold request; register keeps contents
flush  in  1  squash request (taken branch/jump); loads a bubble
idValid  in  1  ID stage holds a real instruction
idCtrl  in  CTRL_W  Control outputs {regDst,aluSrc,memToReg,regWrite,memRead,memWrite,branch,aluOp[1:0],jump}, bit 9 = regDst
idPcPlus4  in  DATA_W  PC+4 of ID instruction
idReadData1  in  DATA_W  rs register value
idReadData2  in  DATA_W  rt register value
idImm  in  DATA_W  sign-extended immediate
idRs / idRt / idRd  in  REG_ADDR_W each  register specifiers (three ports)
exCtrl  out  CTRL_W  registered control bundle
exValid  out  1  EX holds a real instruction
exPcPlus4 / exReadData1 / exReadData2 / exImm  out  DATA_W  registered datapath values
exRs / exRt / exRd  out  REG_ADDR_W  registered specifiers
hazardStall  out  1  combinational load-use stall to PC and IF/ID (hold both)

Behaviour:
- Reset (rst=1 at edge): all outputs and registers cleared to 0; exValid=0. Reset takes priority over every other input.
- Load-use hazard, combinational:
  - hazardStall = exValid & exCtrl.memRead & idValid & exRt!=0 & (exRt==idRs | exRt==idRt).
  - Asserted while the condition holds, independent of stall and flush.
- Edge priority after reset: flush > stall > hazardStall > normal load.
  - flush: exCtrl=0, exValid=0; datapath fields are don't-care but are loaded from ID (no hold). Flush wins over a simultaneous stall and hazard.
  - stall (no flush): every register holds its value, including exValid. hazardStall is still driven from the held values.
  - hazardStall (no flush/stall): bubble inserted. exCtrl=0, exValid=0, so hazardStall deasserts the next cycle. Exactly one bubble per load-use pair.
  - normal: all ex* <= id*. exValid <= idValid. exCtrl <= idValid ? idCtrl : 0.
- Latency: one cycle ID->EX.
- Bubble guarantee: control zeroed means regWrite, memWrite, memRead, branch and jump are all 0, so a bubble has no architectural side effect.
- Reset mid-stall or mid-bubble: reset wins; hazardStall=0 the cycle after reset.
- Wrap-around: no arithmetic inside the block; all values pass through unchanged.

Optional Feature:
- Macro: ID_EX_PERF_COUNTERS_EN.
- When defined:
  - Extra output bubbleCount (32 bits): incremented on each edge where a hazard bubble is inserted. Flush bubbles are not counted.
  - Extra output flushCount (32 bits): incremented on each accepted flush.
  - Both wrap modulo 2^32, are cleared by rst, and hold during stall.
- When undefined: these ports and registers are absent and the rest of the block is functionally identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - CTRL_W and the bit-index constants for each control field;
  - a CTRL_BUBBLE constant (all zeros);
  - aluOp encodings: 00 add, 01 sub, 10 funct.
- One natural sub-module: load_use_detect, a combinational hazard compare reused later by the forwarding unit. The register bank stays in id_ex_stage.

Test Plan:
- Reset: rst=1 for 2 cycles with idCtrl=10'h3FF, idValid=1 -> exCtrl=0, exValid=0, hazardStall=0.
- Normal pass: R-type idCtrl=10'b1001000100, idRd=5'd8, idReadData1=32'h0000_0005 -> next cycle exCtrl/exRd/exReadData1 match, exValid=1.
- Load-use:
  - Stimulus: lw with exRt=9, memRead=1 in EX; ID add with idRs=9.
  - Response: hazardStall=1 that cycle; next cycle exCtrl=0, exValid=0, hazardStall=0; the held add enters EX one cycle later.
- $0 exemption: lw exRt=0, idRs=0 -> hazardStall stays 0, no bubble.
- Stall vs flush:
  - stall=1 for 3 cycles -> ex* frozen.
  - flush=1 together with stall=1 -> exCtrl=0, exValid=0 on that edge.
- Perf counters (macro defined): 2 load-use bubbles, 1 flush -> bubbleCount=2, flushCount=1. Counters unchanged across a stall.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control bundle layout, bubble constant and ALU op encodings.
package pipeline_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 10;

  // Bit positions inside the packed control bundle (bit 9 = regDst).
  localparam int CTRL_REG_DST    = 9;
  localparam int CTRL_ALU_SRC    = 8;
  localparam int CTRL_MEM_TO_REG = 7;
  localparam int CTRL_REG_WRITE  = 6;
  localparam int CTRL_MEM_READ   = 5;
  localparam int CTRL_MEM_WRITE  = 4;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_ALU_OP_HI  = 2;
  localparam int CTRL_ALU_OP_LO  = 1;
  localparam int CTRL_JUMP       = 0;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_e;

  function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEM_READ];
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX boundary bundle: decoded ID inputs, registered EX outputs and the load-use stall.
// Handshake: no valid/ready pair; idValid/exValid tag real instructions and hazardStall
// asks the upstream PC and IF/ID registers to hold for one cycle.
interface id_ex_stage_if;
  import pipeline_pkg::*;

  logic                  idValid;
  logic [CTRL_W-1:0]     idCtrl;
  logic [DATA_W-1:0]     idPcPlus4;
  logic [DATA_W-1:0]     idReadData1;
  logic [DATA_W-1:0]     idReadData2;
  logic [DATA_W-1:0]     idImm;
  logic [REG_ADDR_W-1:0] idRs;
  logic [REG_ADDR_W-1:0] idRt;
  logic [REG_ADDR_W-1:0] idRd;

  logic                  exValid;
  logic [CTRL_W-1:0]     exCtrl;
  logic [DATA_W-1:0]     exPcPlus4;
  logic [DATA_W-1:0]     exReadData1;
  logic [DATA_W-1:0]     exReadData2;
  logic [DATA_W-1:0]     exImm;
  logic [REG_ADDR_W-1:0] exRs;
  logic [REG_ADDR_W-1:0] exRt;
  logic [REG_ADDR_W-1:0] exRd;
  logic                  hazardStall;

  modport master (
    output idValid, idCtrl, idPcPlus4, idReadData1, idReadData2, idImm, idRs, idRt, idRd,
    input  exValid, exCtrl, exPcPlus4, exReadData1, exReadData2, exImm, exRs, exRt, exRd,
    input  hazardStall
  );

  modport slave (
    input  idValid, idCtrl, idPcPlus4, idReadData1, idReadData2, idImm, idRs, idRt, idRd,
    output exValid, exCtrl, exPcPlus4, exReadData1, exReadData2, exImm, exRs, exRt, exRd,
    output hazardStall
  );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use compare between the load in EX and the instruction in ID.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic                  i_ex_valid,
  input  logic                  i_ex_mem_read,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  output logic                  o_hazard
);

  logic w_rt_nonzero;
  logic w_match;

  // $0 is hardwired to zero, so a load into it never creates a dependency.
  assign w_rt_nonzero = (i_ex_rt != '0);
  assign w_match      = (i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt);
  assign o_hazard     = i_ex_valid & i_ex_mem_read & i_id_valid & w_rt_nonzero & w_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, stall hold and flush squash.
// Optional macro ID_EX_PERF_COUNTERS_EN adds bubbleCount/flushCount outputs.
module id_ex_stage
  import pipeline_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_COUNTERS_EN
  ,
  output logic [31:0]  bubbleCount,
  output logic [31:0]  flushCount
`endif
);

  logic                  r_ex_valid;
  logic [CTRL_W-1:0]     r_ex_ctrl;
  logic [DATA_W-1:0]     r_ex_pc_plus4;
  logic [DATA_W-1:0]     r_ex_rd1;
  logic [DATA_W-1:0]     r_ex_rd2;
  logic [DATA_W-1:0]     r_ex_imm;
  logic [REG_ADDR_W-1:0] r_ex_rs;
  logic [REG_ADDR_W-1:0] r_ex_rt;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  w_hazard;

  load_use_detect u_load_use_detect (
    .i_ex_valid    (r_ex_valid),
    .i_ex_mem_read (ctrl_mem_read(r_ex_ctrl)),
    .i_id_valid    (bus.idValid),
    .i_ex_rt       (r_ex_rt),
    .i_id_rs       (bus.idRs),
    .i_id_rt       (bus.idRt),
    .o_hazard      (w_hazard)
  );

  // Datapath fields follow ID on flush and bubble; only control and valid are squashed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_ctrl     <= CTRL_BUBBLE;
      r_ex_pc_plus4 <= '0;
      r_ex_rd1      <= '0;
      r_ex_rd2      <= '0;
      r_ex_imm      <= '0;
      r_ex_rs       <= '0;
      r_ex_rt       <= '0;
      r_ex_rd       <= '0;
    end else if (flush || !stall) begin
      if (flush || w_hazard) begin
        r_ex_valid <= 1'b0;
        r_ex_ctrl  <= CTRL_BUBBLE;
      end else begin
        r_ex_valid <= bus.idValid;
        r_ex_ctrl  <= bus.idValid ? bus.idCtrl : CTRL_BUBBLE;
      end
      r_ex_pc_plus4 <= bus.idPcPlus4;
      r_ex_rd1      <= bus.idReadData1;
      r_ex_rd2      <= bus.idReadData2;
      r_ex_imm      <= bus.idImm;
      r_ex_rs       <= bus.idRs;
      r_ex_rt       <= bus.idRt;
      r_ex_rd       <= bus.idRd;
    end
  end

  assign bus.exValid     = r_ex_valid;
  assign bus.exCtrl      = r_ex_ctrl;
  assign bus.exPcPlus4   = r_ex_pc_plus4;
  assign bus.exReadData1 = r_ex_rd1;
  assign bus.exReadData2 = r_ex_rd2;
  assign bus.exImm       = r_ex_imm;
  assign bus.exRs        = r_ex_rs;
  assign bus.exRt        = r_ex_rt;
  assign bus.exRd        = r_ex_rd;
  assign bus.hazardStall = w_hazard;

`ifdef ID_EX_PERF_COUNTERS_EN
  logic [31:0] r_bubble_count;
  logic [31:0] r_flush_count;

  // Only hazard bubbles count as bubbles; flush squashes are tallied separately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_count <= '0;
      r_flush_count  <= '0;
    end else if (flush) begin
      r_flush_count  <= r_flush_count + 32'd1;
    end else if (!stall && w_hazard) begin
      r_bubble_count <= r_bubble_count + 32'd1;
    end
  end

  assign bubbleCount = r_bubble_count;
  assign flushCount  = r_flush_count;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: driver pushes hand-derived expectations, a negedge monitor checks them.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [9:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } id_t;

  typedef struct packed {
    logic        ctrl_only;
    logic        valid;
    logic [9:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        hz;
  } exp_t;

  localparam int W = $bits(exp_t);

  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  logic [W-1:0] exp_q[$];
  int           tag_q[$];

  id_ex_stage_if bus ();

`ifdef ID_EX_PERF_COUNTERS_EN
  logic [31:0] bubble_count;
  logic [31:0] flush_count;
`endif

  id_ex_stage dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
`ifdef ID_EX_PERF_COUNTERS_EN
    ,
    .bubbleCount (bubble_count),
    .flushCount  (flush_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // lw: aluSrc, memToReg, regWrite, memRead = 10'b0111100000
  localparam id_t V_ALL   = '{1'b1, 10'h3FF, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 5'd9, 5'd9, 5'd9};
  localparam id_t V_RTYPE = '{1'b1, 10'b1001000100, 32'h0000_0104, 32'h0000_0005, 32'h0000_0007, 32'h0, 5'd1, 5'd2, 5'd8};
  localparam id_t V_LW    = '{1'b1, 10'b0111100000, 32'h0000_0200, 32'h0000_1000, 32'h0, 32'h0000_0010, 5'd3, 5'd9, 5'd0};
  localparam id_t V_ADD   = '{1'b1, 10'b1001000100, 32'h0000_0204, 32'h0000_0011, 32'h0000_0022, 32'h0, 5'd9, 5'd4, 5'd10};
  localparam id_t V_LW0   = '{1'b1, 10'b0111100000, 32'h0000_0300, 32'h0000_2000, 32'h0, 32'h0000_0020, 5'd6, 5'd0, 5'd0};
  localparam id_t V_ADD0  = '{1'b1, 10'b1001000100, 32'h0000_0304, 32'h0000_0000, 32'h0000_0033, 32'h0, 5'd0, 5'd5, 5'd11};
  localparam id_t V_INV   = '{1'b0, 10'h3FF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_8000, 5'd31, 5'd30, 5'd29};
  localparam id_t V_NOP   = '0;

  function automatic exp_t exp_ld(input id_t v, input logic hz);
    exp_t e;
    e.ctrl_only = 1'b0;
    e.valid     = v.valid;
    e.ctrl      = v.valid ? v.ctrl : 10'h0;
    e.pc        = v.pc;
    e.d1        = v.d1;
    e.d2        = v.d2;
    e.imm       = v.imm;
    e.rs        = v.rs;
    e.rt        = v.rt;
    e.rd        = v.rd;
    e.hz        = hz;
    return e;
  endfunction

  function automatic exp_t exp_zero(input logic ctrl_only);
    exp_t e;
    e           = '0;
    e.ctrl_only = ctrl_only;
    return e;
  endfunction

  task automatic apply(input id_t v);
    bus.idValid     = v.valid;
    bus.idCtrl      = v.ctrl;
    bus.idPcPlus4   = v.pc;
    bus.idReadData1 = v.d1;
    bus.idReadData2 = v.d2;
    bus.idImm       = v.imm;
    bus.idRs        = v.rs;
    bus.idRt        = v.rt;
    bus.idRd        = v.rd;
  endtask

  // driver: e describes outputs after this edge, with hz evaluated against the new ID inputs
  task automatic step(input int tag, input logic r, input logic st, input logic fl,
                      input id_t v, input exp_t e);
    @(posedge clk);
    #1;
    rst   = r;
    stall = st;
    flush = fl;
    apply(v);
    exp_q.push_back(W'(e));
    tag_q.push_back(tag);
  endtask

`ifdef ID_EX_PERF_COUNTERS_EN
  task automatic check_perf(input int tag, input logic [31:0] b, input logic [31:0] f);
    total++;
    if (bubble_count !== b || flush_count !== f) begin
      bad++;
      $display("FAIL perf_step%0d: got bubbles=%0d flushes=%0d want bubbles=%0d flushes=%0d",
               tag, bubble_count, flush_count, b, f);
    end
  endtask
`endif

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      int   tag;
      logic ok;
      e = exp_q.pop_front();
      tag = tag_q.pop_front();
      a = '{e.ctrl_only, bus.exValid, bus.exCtrl, bus.exPcPlus4, bus.exReadData1, bus.exReadData2,
            bus.exImm, bus.exRs, bus.exRt, bus.exRd, bus.hazardStall};
      if (e.ctrl_only)
        ok = (a.valid === e.valid) && (a.ctrl === e.ctrl) && (a.hz === e.hz);
      else
        ok = (a === e);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL step%0d: got v=%0b c=%h pc=%h d1=%h d2=%h imm=%h rs=%0d rt=%0d rd=%0d hz=%0b want v=%0b c=%h pc=%h d1=%h d2=%h imm=%h rs=%0d rt=%0d rd=%0d hz=%0b",
                 tag, a.valid, a.ctrl, a.pc, a.d1, a.d2, a.imm, a.rs, a.rt, a.rd, a.hz,
                 e.valid, e.ctrl, e.pc, e.d1, e.d2, e.imm, e.rs, e.rt, e.rd, e.hz);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    apply(V_ALL);
    // reset with all-ones ID inputs
    step(1,  1, 0, 0, V_ALL,   exp_zero(0));
    step(2,  0, 0, 0, V_RTYPE, exp_zero(0));
    // normal R-type pass, then lw followed by dependent add
    step(3,  0, 0, 0, V_LW,    exp_ld(V_RTYPE, 0));
    step(4,  0, 0, 0, V_ADD,   exp_ld(V_LW, 1));
    step(5,  0, 0, 0, V_ADD,   exp_zero(1));
    step(6,  0, 0, 0, V_LW0,   exp_ld(V_ADD, 0));
    // load into $0 never stalls
    step(7,  0, 0, 0, V_ADD0,  exp_ld(V_LW0, 0));
    step(8,  0, 0, 0, V_RTYPE, exp_ld(V_ADD0, 0));
    // three stalled edges freeze the R-type
    step(9,  0, 1, 0, V_LW,    exp_ld(V_RTYPE, 0));
`ifdef ID_EX_PERF_COUNTERS_EN
    check_perf(9, 32'd1, 32'd0);
`endif
    step(10, 0, 1, 0, V_LW,    exp_ld(V_RTYPE, 0));
    step(11, 0, 1, 0, V_LW,    exp_ld(V_RTYPE, 0));
    step(12, 0, 0, 0, V_LW,    exp_ld(V_RTYPE, 0));
`ifdef ID_EX_PERF_COUNTERS_EN
    check_perf(12, 32'd1, 32'd0);
`endif
    // hazard visible under stall, then flush beats stall and hazard
    step(13, 0, 1, 0, V_ADD,   exp_ld(V_LW, 1));
    step(14, 0, 1, 1, V_ADD,   exp_ld(V_LW, 1));
    step(15, 0, 0, 0, V_ADD,   exp_zero(1));
    step(16, 0, 0, 0, V_LW,    exp_ld(V_ADD, 0));
    step(17, 0, 0, 0, V_ADD,   exp_ld(V_LW, 1));
    step(18, 0, 0, 0, V_ADD,   exp_zero(1));
`ifdef ID_EX_PERF_COUNTERS_EN
    check_perf(18, 32'd2, 32'd1);
`endif
    // reset while a hazard is pending
    step(19, 0, 0, 0, V_LW,    exp_ld(V_ADD, 0));
    step(20, 1, 0, 0, V_ADD,   exp_ld(V_LW, 1));
    step(21, 0, 0, 0, V_ADD,   exp_zero(0));
`ifdef ID_EX_PERF_COUNTERS_EN
    check_perf(21, 32'd0, 32'd0);
`endif
    // invalid ID instruction loads zero control but passes datapath through
    step(22, 0, 0, 0, V_INV,   exp_ld(V_ADD, 0));
    step(23, 0, 0, 0, V_NOP,   exp_ld(V_INV, 0));
    step(24, 0, 0, 0, V_NOP,   exp_ld(V_NOP, 0));

    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got pending=%0d want pending=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
